// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: decodes opcode/funct, sequences the datapath
// one phase per clock, stalls on mem_ready and counts retired instructions.
module mc_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       alu_ctrl,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             instr_done,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OFF = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EX     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    state_t state_q, state_d;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = S_RST;
        alu_ctrl   = ALU_OFF;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:      state_d = S_R_EX;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                state_d   = S_R_WB;
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a default-width instance plus a 2-bit
// counter instance driven by the same inputs to exercise retired wrap.
module tb_mc_controller;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OFF = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic clk = 1'b0;
    logic rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic [2:0] alu_ctrl;
    logic alu_src_a, pc_en, iord, mem_read, mem_write, ir_write;
    logic reg_dst, mem_to_reg, reg_write, instr_done, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] state;
    logic [15:0] retired;

    logic [2:0] b_alu_ctrl;
    logic b_alu_src_a, b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write;
    logic b_reg_dst, b_mem_to_reg, b_reg_write, b_instr_done, b_illegal;
    logic [1:0] b_alu_src_b, b_pc_src;
    logic [3:0] b_state;
    logic [1:0] b_retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .instr_done(instr_done), .illegal(illegal), .state(state), .retired(retired)
    );

    mc_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_ctrl(b_alu_ctrl), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .pc_src(b_pc_src), .pc_en(b_pc_en), .iord(b_iord),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .instr_done(b_instr_done), .illegal(b_illegal), .state(b_state), .retired(b_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the always-true exclusivity rules.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 0);
        chk("wr_pc_excl", {31'd0, reg_write & pc_en}, 0);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held two cycles.
        tick(); tick();
        rst_n = 1'b1; #1;
        chk("rst_state", state, 0);
        chk("rst_alu", alu_ctrl, ALU_OFF);
        chk("rst_en", {mem_read, mem_write, ir_write, pc_en, reg_write, instr_done, illegal}, 0);
        chk("rst_sel", {alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg}, 0);
        chk("rst_retired", retired, 0);
        tick();
        chk("fetch_state", state, 1);
        chk("fetch_sig", {mem_read, alu_src_b, ir_write, pc_en}, {1'b1, 2'b01, 1'b1, 1'b1});
        chk("fetch_alu", alu_ctrl, ALU_ADD);

        // R-type slt.
        opcode = 6'b000000; funct = 6'b101010;
        tick(); chk("r_decode", state, 2); chk("decode_srcb", alu_src_b, 3);
        chk("decode_alu", alu_ctrl, ALU_ADD);
        tick(); chk("r_ex", state, 7); chk("r_ex_alu", alu_ctrl, ALU_SLT);
        chk("r_ex_srca", alu_src_a, 1);
        tick(); chk("r_wb", state, 8);
        chk("r_wb_sig", {reg_write, reg_dst, instr_done}, 3'b111);
        tick(); chk("r_back", state, 1); chk("r_retired", retired, 1);

        // lw with 3-cycle stall in MEM_RD (8 cycles total).
        opcode = 6'b100011;
        tick(); chk("lw_decode", state, 2);
        tick(); chk("lw_addr", state, 3); chk("lw_addr_srcb", alu_src_b, 2);
        mem_ready = 1'b0;
        tick(); chk("lw_rd", state, 4); chk("lw_rd_sig", {mem_read, iord}, 2'b11);
        tick(); chk("lw_stall1", state, 4);
        tick(); chk("lw_stall2", state, 4);
        tick(); chk("lw_stall3", state, 4);
        mem_ready = 1'b1;
        tick(); chk("lw_wb", state, 5);
        chk("lw_wb_sig", {reg_write, mem_to_reg, instr_done}, 3'b111);
        tick(); chk("lw_back", state, 1); chk("lw_retired", retired, 2);

        // beq taken then not taken.
        opcode = 6'b000100; zero = 1'b1;
        tick(); tick(); chk("beq_state", state, 9);
        chk("beq_t_pc", {pc_en, pc_src}, {1'b1, 2'b01});
        chk("beq_t_alu", alu_ctrl, ALU_SUB);
        chk("beq_t_done", instr_done, 1);
        tick(); chk("beq_retired", retired, 3);
        zero = 1'b0;
        tick(); tick(); chk("beq_nt_state", state, 9);
        chk("beq_nt_pc_en", pc_en, 0); chk("beq_nt_alu", alu_ctrl, ALU_SUB);
        tick(); chk("beq_nt_retired", retired, 4);

        // Illegal opcode, then illegal funct.
        opcode = 6'b111111;
        tick(); chk("ill_op_state", state, 2); chk("ill_op_pulse", illegal, 1);
        tick(); chk("ill_op_back", state, 1); chk("ill_op_clear", illegal, 0);
        chk("ill_op_retired", retired, 4);
        opcode = 6'b000000; funct = 6'b000111;
        tick(); tick(); chk("ill_fn_state", state, 7);
        chk("ill_fn_pulse", illegal, 1); chk("ill_fn_alu", alu_ctrl, ALU_OFF);
        chk("ill_fn_wr", reg_write, 0);
        tick(); chk("ill_fn_back", state, 1); chk("ill_fn_retired", retired, 4);

        // addi.
        opcode = 6'b001000;
        tick(); tick(); chk("addi_ex", state, 11);
        chk("addi_ex_sig", {alu_src_a, alu_src_b, alu_ctrl}, {1'b1, 2'b10, ALU_ADD});
        tick(); chk("addi_wb", state, 12);
        chk("addi_wb_sig", {reg_write, reg_dst, instr_done}, 3'b101);
        tick(); chk("addi_retired", retired, 5);

        // sw with reset asserted mid-MEM_WR.
        opcode = 6'b101011;
        tick(); tick(); chk("sw_addr", state, 3);
        mem_ready = 1'b0;
        tick(); chk("sw_wr", state, 6);
        chk("sw_wr_sig", {mem_write, iord, instr_done}, 3'b110);
        mem_ready = 1'b1; #1;
        chk("sw_done_gate", instr_done, 1);
        rst_n = 1'b0;
        tick(); chk("midrst_state", state, 0); chk("midrst_wr", mem_write, 0);
        chk("midrst_retired", retired, 0);
        rst_n = 1'b1;
        tick(); chk("midrst_fetch", state, 1);

        // Five jumps: 16-bit counter reaches 5, 2-bit counter wraps to 1.
        opcode = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            tick(); tick();
            chk("j_state", state, 10);
            chk("j_pc", {pc_en, pc_src}, {1'b1, 2'b10});
            tick();
        end
        chk("j_retired", retired, 5);
        chk("wrap_retired", b_retired, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
